// File: rtl/rv_decode_stage.sv
// rv_decode_stage
// RV32I decode stage, with RV32M when EN_M=1. Fetched instructions wait in a
// small FIFO. The FIFO head is decoded combinationally, and the result is
// captured in an output register that feeds execute through a valid/ready
// handshake.
module rv_decode_stage #(
    parameter int DEPTH  = 2,
    parameter int EN_M   = 0,
    parameter int CNT_W  = 16,
    parameter int FLAG_W = 37 + 8 * EN_M
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [FLAG_W-1:0] out_flags,
    output logic              out_illegal,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic              out_rd_we,
    output logic [31:0]       out_imm,
    output logic [CNT_W-1:0]  illegal_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] C_DEPTH = (PTR_W + 1)'(DEPTH);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULT = 7'b0000001;

    // The flag vector is always built at full RV32I+M width. When EN_M=0 the
    // M bits are never set, so slicing to FLAG_W drops nothing of value.
    localparam int ALL_FLAGS = 45;

    // FIFO storage and bookkeeping
    logic [31:0]    r_instrMem [DEPTH];
    logic [31:0]    r_pcMem    [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;

    // Output register
    logic              r_outValid;
    logic [31:0]       r_outPc;
    logic [FLAG_W-1:0] r_outFlags;
    logic              r_outIllegal;
    logic [4:0]        r_outRd;
    logic [4:0]        r_outRs1;
    logic [4:0]        r_outRs2;
    logic              r_outRdWe;
    logic [31:0]       r_outImm;
    logic [CNT_W-1:0]  r_illegalCnt;

    // Handshake and decode wires
    logic                 w_push;
    logic                 w_load;
    logic [31:0]          w_headInstr;
    logic [31:0]          w_headPc;
    logic [6:0]           w_opcode;
    logic [2:0]           w_funct3;
    logic [6:0]           w_funct7;
    logic [ALL_FLAGS-1:0] w_allFlags;
    logic                 w_illegal;
    logic [31:0]          w_imm;
    logic                 w_rdWe;

    assign in_ready    = (r_count < C_DEPTH);
    assign w_push      = in_valid & in_ready;
    assign w_load      = (r_count != '0) & (~r_outValid | out_ready);
    assign w_headInstr = r_instrMem[r_rdPtr];
    assign w_headPc    = r_pcMem[r_rdPtr];
    assign w_opcode    = w_headInstr[6:0];
    assign w_funct3    = w_headInstr[14:12];
    assign w_funct7    = w_headInstr[31:25];

    // Write accepted instructions into the FIFO (storage needs no reset)
    always_ff @(posedge clk) begin
        if (w_push && !rst && !flush) begin
            r_instrMem[r_wrPtr] <= in_instr;
            r_pcMem[r_wrPtr]    <= in_pc;
        end
    end

    // FIFO pointers and occupancy; flush wins over same-cycle push and pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_load) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // One-hot instruction flags for the FIFO head; no flag means illegal
    always_comb begin
        w_allFlags = '0;
        case (w_opcode)
            OPC_BRANCH: begin
                case (w_funct3)
                    3'd0: w_allFlags[0] = 1'b1;
                    3'd1: w_allFlags[1] = 1'b1;
                    3'd4: w_allFlags[2] = 1'b1;
                    3'd5: w_allFlags[3] = 1'b1;
                    3'd6: w_allFlags[4] = 1'b1;
                    3'd7: w_allFlags[5] = 1'b1;
                    default: ;
                endcase
            end
            OPC_OPIMM: begin
                case (w_funct3)
                    3'd0: w_allFlags[6]  = 1'b1;
                    3'd2: w_allFlags[7]  = 1'b1;
                    3'd3: w_allFlags[8]  = 1'b1;
                    3'd4: w_allFlags[9]  = 1'b1;
                    3'd6: w_allFlags[10] = 1'b1;
                    3'd7: w_allFlags[11] = 1'b1;
                    3'd1: w_allFlags[12] = (w_funct7 == F7_ZERO);
                    3'd5: begin
                        w_allFlags[13] = (w_funct7 == F7_ZERO);
                        w_allFlags[14] = (w_funct7 == F7_ALT);
                    end
                    default: ;
                endcase
            end
            OPC_OP: begin
                if (w_funct7 == F7_ZERO) begin
                    case (w_funct3)
                        3'd0: w_allFlags[15] = 1'b1;
                        3'd1: w_allFlags[17] = 1'b1;
                        3'd2: w_allFlags[18] = 1'b1;
                        3'd3: w_allFlags[19] = 1'b1;
                        3'd4: w_allFlags[20] = 1'b1;
                        3'd5: w_allFlags[21] = 1'b1;
                        3'd6: w_allFlags[23] = 1'b1;
                        3'd7: w_allFlags[24] = 1'b1;
                        default: ;
                    endcase
                end else if (w_funct7 == F7_ALT) begin
                    w_allFlags[16] = (w_funct3 == 3'd0);
                    w_allFlags[22] = (w_funct3 == 3'd5);
                end else if (w_funct7 == F7_MULT && EN_M != 0) begin
                    w_allFlags[6'd37 + {3'd0, w_funct3}] = 1'b1;
                end
            end
            OPC_LUI:   w_allFlags[25] = 1'b1;
            OPC_AUIPC: w_allFlags[26] = 1'b1;
            OPC_JAL:   w_allFlags[27] = 1'b1;
            OPC_JALR:  w_allFlags[28] = (w_funct3 == 3'd0);
            OPC_LOAD: begin
                case (w_funct3)
                    3'd0: w_allFlags[29] = 1'b1;
                    3'd1: w_allFlags[30] = 1'b1;
                    3'd2: w_allFlags[31] = 1'b1;
                    3'd4: w_allFlags[32] = 1'b1;
                    3'd5: w_allFlags[33] = 1'b1;
                    default: ;
                endcase
            end
            OPC_STORE: begin
                case (w_funct3)
                    3'd0: w_allFlags[34] = 1'b1;
                    3'd1: w_allFlags[35] = 1'b1;
                    3'd2: w_allFlags[36] = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign w_illegal = (w_allFlags == '0);
    assign w_rdWe    = ~w_illegal & (w_opcode != OPC_BRANCH) &
                       (w_opcode != OPC_STORE) & (w_headInstr[11:7] != 5'd0);

    // Format-correct immediate; shift amounts are zero-extended
    always_comb begin
        w_imm = '0;
        case (w_opcode)
            OPC_OPIMM: begin
                if (w_funct3 == 3'd1 || w_funct3 == 3'd5) begin
                    w_imm = {27'd0, w_headInstr[24:20]};
                end else begin
                    w_imm = {{20{w_headInstr[31]}}, w_headInstr[31:20]};
                end
            end
            OPC_JALR, OPC_LOAD:
                w_imm = {{20{w_headInstr[31]}}, w_headInstr[31:20]};
            OPC_STORE:
                w_imm = {{20{w_headInstr[31]}}, w_headInstr[31:25], w_headInstr[11:7]};
            OPC_BRANCH:
                w_imm = {{20{w_headInstr[31]}}, w_headInstr[7], w_headInstr[30:25],
                         w_headInstr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                w_imm = {w_headInstr[31:12], 12'd0};
            OPC_JAL:
                w_imm = {{12{w_headInstr[31]}}, w_headInstr[19:12], w_headInstr[20],
                         w_headInstr[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    // Output register: load the decoded head when free, hold while stalled
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_outValid   <= 1'b0;
            r_outPc      <= '0;
            r_outFlags   <= '0;
            r_outIllegal <= 1'b0;
            r_outRd      <= '0;
            r_outRs1     <= '0;
            r_outRs2     <= '0;
            r_outRdWe    <= 1'b0;
            r_outImm     <= '0;
        end else if (w_load) begin
            r_outValid   <= 1'b1;
            r_outPc      <= w_headPc;
            r_outFlags   <= w_allFlags[FLAG_W-1:0];
            r_outIllegal <= w_illegal;
            r_outRd      <= w_headInstr[11:7];
            r_outRs1     <= w_headInstr[19:15];
            r_outRs2     <= w_headInstr[24:20];
            r_outRdWe    <= w_rdWe;
            r_outImm     <= w_illegal ? 32'd0 : w_imm;
        end else if (out_ready) begin
            r_outValid   <= 1'b0;
        end
    end

    // Saturating count of illegal instructions handed to execute
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegalCnt <= '0;
        end else if (!flush && r_outValid && out_ready && r_outIllegal &&
                     r_illegalCnt != '1) begin
            r_illegalCnt <= r_illegalCnt + 1'b1;
        end
    end

    assign out_valid   = r_outValid;
    assign out_pc      = r_outPc;
    assign out_flags   = r_outFlags;
    assign out_illegal = r_outIllegal;
    assign out_rd      = r_outRd;
    assign out_rs1     = r_outRs1;
    assign out_rs2     = r_outRs2;
    assign out_rd_we   = r_outRdWe;
    assign out_imm     = r_outImm;
    assign illegal_cnt = r_illegalCnt;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Testbench for rv_decode_stage: two instances share one stimulus stream,
// one without RV32M (4-bit counter) and one with RV32M (16-bit counter).
// The reference is a mask/match instruction table plus a queue model.
module tb_rv_decode_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_ready;

    logic        in_ready0, out_valid0, out_illegal0, out_rd_we0;
    logic [31:0] out_pc0, out_imm0;
    logic [36:0] out_flags0;
    logic [4:0]  out_rd0, out_rs10, out_rs20;
    logic [3:0]  illegal_cnt0;

    logic        in_ready1, out_valid1, out_illegal1, out_rd_we1;
    logic [31:0] out_pc1, out_imm1;
    logic [44:0] out_flags1;
    logic [4:0]  out_rd1, out_rs11, out_rs21;
    logic [15:0] illegal_cnt1;

    int vectors = 0;
    int miscompares = 0;

    rv_decode_stage #(.DEPTH(DEPTH), .EN_M(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid0), .out_ready(out_ready), .out_pc(out_pc0),
        .out_flags(out_flags0), .out_illegal(out_illegal0), .out_rd(out_rd0),
        .out_rs1(out_rs10), .out_rs2(out_rs20), .out_rd_we(out_rd_we0),
        .out_imm(out_imm0), .illegal_cnt(illegal_cnt0)
    );

    rv_decode_stage #(.DEPTH(DEPTH), .EN_M(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid1), .out_ready(out_ready), .out_pc(out_pc1),
        .out_flags(out_flags1), .out_illegal(out_illegal1), .out_rd(out_rd1),
        .out_rs1(out_rs11), .out_rs2(out_rs21), .out_rd_we(out_rd_we1),
        .out_imm(out_imm1), .illegal_cnt(illegal_cnt1)
    );

    always #5 clk = ~clk;

    // Instruction table in flag order: an instruction matches entry i when
    // (instr & MASK[i]) == MATCH[i]; the last eight entries are RV32M.
    localparam logic [31:0] MASK [45] = '{
        32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F,
        32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'h7F, 32'h7F, 32'h7F, 32'h707F,
        32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F,
        32'h707F, 32'h707F, 32'h707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F
    };
    localparam logic [31:0] MATCH [45] = '{
        32'h0063, 32'h1063, 32'h4063, 32'h5063, 32'h6063, 32'h7063,
        32'h0013, 32'h2013, 32'h3013, 32'h4013, 32'h6013, 32'h7013,
        32'h1013, 32'h5013, 32'h40005013,
        32'h0033, 32'h40000033, 32'h1033, 32'h2033, 32'h3033,
        32'h4033, 32'h5033, 32'h40005033, 32'h6033, 32'h7033,
        32'h37, 32'h17, 32'h6F, 32'h0067,
        32'h0003, 32'h1003, 32'h2003, 32'h4003, 32'h5003,
        32'h0023, 32'h1023, 32'h2023,
        32'h02000033, 32'h02001033, 32'h02002033, 32'h02003033,
        32'h02004033, 32'h02005033, 32'h02006033, 32'h02007033
    };

    function automatic int decodeIdx(logic [31:0] ins, bit enM);
        for (int i = 0; i < 45; i++) begin
            if ((ins & MASK[i]) == MATCH[i] && (i < 37 || enM)) return i;
        end
        return -1;
    endfunction

    function automatic logic [63:0] expFlags(logic [31:0] ins, bit enM);
        int idx;
        idx = decodeIdx(ins, enM);
        return (idx >= 0) ? (64'd1 << idx) : 64'd0;
    endfunction

    function automatic logic [31:0] expImm(logic [31:0] ins, int idx);
        if (idx < 0) return 32'd0;
        if (idx <= 5) return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        if (idx <= 11 || idx == 28 || (idx >= 29 && idx <= 33))
            return {{20{ins[31]}}, ins[31:20]};
        if (idx <= 14) return {27'd0, ins[24:20]};
        if (idx <= 24 || idx >= 37) return 32'd0;
        if (idx <= 26) return {ins[31:12], 12'd0};
        if (idx == 27) return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        return {{20{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic expRdWe(logic [31:0] ins, int idx);
        if (idx < 0) return 1'b0;
        if (idx <= 5 || (idx >= 34 && idx <= 36)) return 1'b0;
        return ins[11:7] != 5'd0;
    endfunction

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Queue model of the FIFO plus the output slot
    typedef struct { logic [31:0] pc; logic [31:0] instr; } item_t;
    item_t q[$];
    item_t slot;
    bit    slotValid = 0;
    bit    slotZero  = 1;
    bit    modelLive = 0;
    int    expCnt0 = 0;
    int    expCnt1 = 0;

    // Advance the model at every rising edge from the inputs driven before it
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            slotValid = 0;
            slotZero  = 1;
            expCnt0   = 0;
            expCnt1   = 0;
            modelLive = 1;
        end else if (modelLive) begin
            if (flush) begin
                q.delete();
                slotValid = 0;
                slotZero  = 1;
            end else begin
                int  sz;
                bit  handoff;
                sz = q.size();
                handoff = slotValid && out_ready;
                if (handoff && decodeIdx(slot.instr, 0) < 0 && expCnt0 < 15) expCnt0++;
                if (handoff && decodeIdx(slot.instr, 1) < 0 && expCnt1 < 65535) expCnt1++;
                if (sz > 0 && (!slotValid || out_ready)) begin
                    slot = q.pop_front();
                    slotValid = 1;
                    slotZero  = 0;
                end else if (handoff) begin
                    slotValid = 0;
                end
                if (in_valid && sz < DEPTH) q.push_back('{pc: in_pc, instr: in_instr});
            end
        end
    end

    // Compare both instances against the model on every falling edge
    always @(negedge clk) begin
        if (modelLive) begin
            int idx0;
            int idx1;
            checkOutput("in_ready0", {63'd0, in_ready0}, {63'd0, q.size() < DEPTH});
            checkOutput("in_ready1", {63'd0, in_ready1}, {63'd0, q.size() < DEPTH});
            checkOutput("out_valid0", {63'd0, out_valid0}, {63'd0, slotValid});
            checkOutput("out_valid1", {63'd0, out_valid1}, {63'd0, slotValid});
            checkOutput("illegal_cnt0", {60'd0, illegal_cnt0}, 64'(expCnt0));
            checkOutput("illegal_cnt1", {48'd0, illegal_cnt1}, 64'(expCnt1));
            if (slotValid) begin
                idx0 = decodeIdx(slot.instr, 0);
                idx1 = decodeIdx(slot.instr, 1);
                checkOutput("out_pc0", {32'd0, out_pc0}, {32'd0, slot.pc});
                checkOutput("out_pc1", {32'd0, out_pc1}, {32'd0, slot.pc});
                checkOutput("out_rd0", {59'd0, out_rd0}, {59'd0, slot.instr[11:7]});
                checkOutput("out_rs1_0", {59'd0, out_rs10}, {59'd0, slot.instr[19:15]});
                checkOutput("out_rs2_0", {59'd0, out_rs20}, {59'd0, slot.instr[24:20]});
                checkOutput("out_rd1", {59'd0, out_rd1}, {59'd0, slot.instr[11:7]});
                checkOutput("out_flags0", {27'd0, out_flags0}, expFlags(slot.instr, 0));
                checkOutput("out_flags1", {19'd0, out_flags1}, expFlags(slot.instr, 1));
                checkOutput("out_illegal0", {63'd0, out_illegal0}, {63'd0, idx0 < 0});
                checkOutput("out_illegal1", {63'd0, out_illegal1}, {63'd0, idx1 < 0});
                if (idx0 >= 0) begin
                    checkOutput("out_imm0", {32'd0, out_imm0}, {32'd0, expImm(slot.instr, idx0)});
                    checkOutput("out_rd_we0", {63'd0, out_rd_we0}, {63'd0, expRdWe(slot.instr, idx0)});
                end
                if (idx1 >= 0) begin
                    checkOutput("out_imm1", {32'd0, out_imm1}, {32'd0, expImm(slot.instr, idx1)});
                    checkOutput("out_rd_we1", {63'd0, out_rd_we1}, {63'd0, expRdWe(slot.instr, idx1)});
                end
            end else if (slotZero) begin
                checkOutput("zero_pc0", {32'd0, out_pc0}, 64'd0);
                checkOutput("zero_flags1", {19'd0, out_flags1}, 64'd0);
                checkOutput("zero_imm0", {32'd0, out_imm0}, 64'd0);
                checkOutput("zero_rd0", {59'd0, out_rd0}, 64'd0);
                checkOutput("zero_ill0", {63'd0, out_illegal0}, 64'd0);
                checkOutput("zero_we1", {63'd0, out_rd_we1}, 64'd0);
            end
        end
    end

    // Drive one cycle of inputs, then step just past the next rising edge
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                 input logic rdy, input logic fl, input logic rs);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        rst       = rs;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] mix [20] = '{
        32'h00112623, 32'h008000EF, 32'h000080E7, 32'h4020D193, 32'h402081B3,
        32'h0040D283, 32'h00001317, 32'h00002063, 32'h40209093, 32'h80000537,
        32'hFFF14093, 32'h0220C0B3, 32'h02003033, 32'h0000000F, 32'hFF5FF06F,
        32'h00003083, 32'h00313023, 32'h00C0A023, 32'h00001073, 32'h0020F033
    };

    // Directed scenarios
    initial begin
        int idx;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;

        checkOutput("pin_addi_idx", 64'(decodeIdx(32'h00500093, 1)), 64'd6);
        checkOutput("pin_beq_imm", {32'd0, expImm(32'hFE208CE3, 0)}, 64'hFFFFFFF8);
        checkOutput("pin_lui_imm", {32'd0, expImm(32'h123452B7, 25)}, 64'h12345000);
        checkOutput("pin_lui_we", {63'd0, expRdWe(32'h123452B7, 25)}, 64'd1);
        checkOutput("pin_mul_noM", 64'(decodeIdx(32'h02208033, 0)), 64'hFFFFFFFFFFFFFFFF);
        checkOutput("pin_mul_M", 64'(decodeIdx(32'h02208033, 1)), 64'd37);
        checkOutput("pin_jal_imm", {32'd0, expImm(32'hFF5FF06F, 27)}, 64'hFFFFFFF4);

        repeat (2) @(posedge clk);
        #1;

        // addi, beq, lui back to back with execute always ready
        applyStimulus(1, 32'h00500093, 32'h100, 1, 0, 0);
        applyStimulus(1, 32'hFE208CE3, 32'h104, 1, 0, 0);
        checkOutput("lit_addi_valid", {63'd0, out_valid0}, 64'd1);
        checkOutput("lit_addi_imm", {32'd0, out_imm0}, 64'h5);
        checkOutput("lit_addi_flag", {63'd0, out_flags0[6]}, 64'd1);
        checkOutput("lit_addi_pc", {32'd0, out_pc0}, 64'h100);
        applyStimulus(1, 32'h123452B7, 32'h108, 1, 0, 0);
        checkOutput("lit_beq_imm", {32'd0, out_imm0}, 64'hFFFFFFF8);
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 0);
        checkOutput("lit_lui_rd", {59'd0, out_rd0}, 64'd5);

        // all-zero word and mul: illegal without M, legal with M
        applyStimulus(1, 32'h00000000, 32'h200, 1, 0, 0);
        applyStimulus(1, 32'h02208033, 32'h204, 1, 0, 0);
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 0);
        checkOutput("lit_mul_flag1", {63'd0, out_flags1[37]}, 64'd1);
        checkOutput("lit_mul_ill0", {63'd0, out_illegal0}, 64'd1);
        checkOutput("lit_mul_we1", {63'd0, out_rd_we1}, 64'd0);
        repeat (2) applyStimulus(0, 32'h0, 32'h0, 1, 0, 0);
        checkOutput("lit_cnt0_two", {60'd0, illegal_cnt0}, 64'd2);
        checkOutput("lit_cnt1_one", {48'd0, illegal_cnt1}, 64'd1);

        // backpressure: five offered, three accepted, then drain in order
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'h00100093 + (i << 20), 32'h300 + i * 4, 0, 0, 0);
        checkOutput("lit_full_ready", {63'd0, in_ready0}, 64'd0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 32'h0, 32'h0, 1, 0, 0);

        // mixed stream with intermittent backpressure
        idx = 0;
        for (int c = 0; c < 120 && idx < 20; c++) begin
            bit acc;
            acc = (q.size() < DEPTH);
            applyStimulus(1, mix[idx], 32'h2000 + idx * 4, (c % 3) != 1, 0, 0);
            if (acc) idx++;
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 32'h0, 1, 0, 0);

        // flush with three in flight and a push in the same cycle
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h00000013 + (i << 7), 32'h400 + i * 4, 0, 0, 0);
        applyStimulus(1, 32'h00700393, 32'h40C, 0, 1, 0);
        checkOutput("lit_flush_valid", {63'd0, out_valid0}, 64'd0);
        checkOutput("lit_flush_ready", {63'd0, in_ready0}, 64'd1);
        applyStimulus(1, 32'h00900493, 32'h500, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 32'h0, 1, 0, 0);

        // reset mid-stream
        applyStimulus(1, 32'hFFFFFFFF, 32'h600, 1, 0, 0);
        applyStimulus(1, 32'hFFFFFFFF, 32'h604, 1, 0, 0);
        applyStimulus(1, 32'h00500093, 32'h608, 1, 0, 1);
        checkOutput("lit_rst_valid", {63'd0, out_valid0}, 64'd0);
        checkOutput("lit_rst_cnt0", {60'd0, illegal_cnt0}, 64'd0);

        // saturate the 4-bit counter with 18 illegal handoffs
        for (int i = 0; i < 18; i++) applyStimulus(1, 32'hFFFFFFFF, 32'h700 + i * 4, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 32'h0, 1, 0, 0);
        checkOutput("lit_sat_cnt0", {60'd0, illegal_cnt0}, 64'hF);
        checkOutput("lit_sat_cnt1", {48'd0, illegal_cnt1}, 64'd18);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
